// File: rtl/fetch_queue.sv
// fetch_queue
// Decoupled instruction-fetch front end. It issues at most one sequential IMEM
// read per cycle, buffers each returned word with its PC in a DEPTH-entry FIFO,
// and presents the FIFO head to decode through a valid/ready handshake. A
// redirect from EX flushes the FIFO and drops any response arriving that cycle.
// In the same cycle it issues the fetch of the new target, so no bubble is added.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   redirect_valid  EX requests a PC change this cycle
//   redirect_pc     new fetch target (bits [1:0] ignored)
//   imem_en         IMEM read request this cycle
//   imem_addr       IMEM word-aligned byte address (holds fetch_pc when idle)
//   imem_rdata      IMEM read data, valid the cycle after imem_en
//   id_valid        head entry presented to decode
//   id_ready        decode accepts the head entry
//   id_instr        head instruction, NOP when id_valid=0
//   id_pc           head PC, 0 when id_valid=0
//   occupancy       number of entries currently stored
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_en,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_instr,
    output logic [XLEN-1:0]            id_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [XLEN-1:0]  fetch_pc;
    logic             vld_p1;        // one request outstanding at IMEM
    logic [XLEN-1:0]  pc_p1;         // PC of that outstanding request
    logic [31:0]      fifo_instr [DEPTH];
    logic [XLEN-1:0]  fifo_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  redirect_base;
    logic [CNT_W:0]   used;
    logic             credit_ok;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unused_pc_bits;

    assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Credit counts stored entries plus the outstanding response. A pop in the
    // same cycle is deliberately not credited, which keeps overflow impossible.
    assign used      = {1'b0, count} + (CNT_W+1)'(vld_p1);
    assign credit_ok = used < (CNT_W+1)'(DEPTH);

    // Gating with rst_n keeps imem_en low while reset is held; the first request
    // goes out as soon as reset releases.
    assign issue     = rst_n && (redirect_valid || credit_ok);
    assign imem_en   = issue;
    assign imem_addr = (rst_n && redirect_valid) ? redirect_base : fetch_pc;

    assign push      = vld_p1 && !redirect_valid;
    assign id_valid  = (count != '0) && !redirect_valid;
    assign pop       = id_valid && id_ready;

    assign id_instr  = id_valid ? fifo_instr[rd_ptr] : NOP;
    assign id_pc     = id_valid ? fifo_pc[rd_ptr]    : '0;
    assign occupancy = count;

    // ---- stage p0 -> p1: request issue, FIFO control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base + XLEN'(4);
            vld_p1   <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                vld_p1   <= 1'b1;
            end else begin
                vld_p1   <= 1'b0;
            end
        end
    end

    // ---- stage p1 -> FIFO: response capture (data path, not reset) ----
    always_ff @(posedge clk) begin
        if (redirect_valid) begin
            pc_p1 <= redirect_base;
        end else if (issue) begin
            pc_p1 <= fetch_pc;
        end
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= pc_p1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  occupancy;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Memory content is a function of the address: word i lives at address 4i.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a >> 2) ^ 32'hC300_0000;
    endfunction

    // Synchronous IMEM: data appears the cycle after the request.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= memword(imem_addr);
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference model: an ordered list of delivered {instr, pc} pairs, the next
    // sequential fetch address, and whether one response is still owed by IMEM.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_owed_pc;
    bit          m_owed;

    task automatic model_reset();
        mq.delete();
        m_fetch   = RESET_PC;
        m_owed    = 1'b0;
        m_owed_pc = '0;
    endtask

    // One clock cycle: drive inputs, compare every output at the falling edge,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        logic [31:0] base;
        logic [31:0] e_addr;
        bit          e_en;
        bit          e_vld;
        int          n;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(negedge clk);
        base   = {rpc[31:2], 2'b00};
        n      = mq.size();
        e_vld  = (n > 0) && !rv;
        e_en   = rv || ((n + int'(m_owed)) < DEPTH);
        e_addr = rv ? base : m_fetch;
        chk("imem_en",   32'(imem_en),   32'(e_en));
        chk("imem_addr", imem_addr,      e_addr);
        chk("id_valid",  32'(id_valid),  32'(e_vld));
        chk("occupancy", 32'(occupancy), 32'(n));
        if (e_vld) begin
            chk("id_instr", id_instr, mq[0].instr);
            chk("id_pc",    id_pc,    mq[0].pc);
        end else begin
            chk("id_instr_idle", id_instr, NOP);
            chk("id_pc_idle",    id_pc,    32'h0);
        end
        if (rv) begin
            mq.delete();
            m_owed    = 1'b1;
            m_owed_pc = base;
            m_fetch   = base + 32'd4;
        end else begin
            if (e_vld && rdy) void'(mq.pop_front());
            if (m_owed) mq.push_back('{memword(m_owed_pc), m_owed_pc});
            if (e_en) begin
                m_owed    = 1'b1;
                m_owed_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end else begin
                m_owed    = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},    32'(imem_en),   32'h0);
        chk({tag, "_addr"},  imem_addr,      RESET_PC);
        chk({tag, "_vld"},   32'(id_valid),  32'h0);
        chk({tag, "_instr"}, id_instr,       NOP);
        chk({tag, "_pc"},    id_pc,          32'h0);
        chk({tag, "_occ"},   32'(occupancy), 32'h0);
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream with decode always ready
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // Backpressure fill
        repeat (8) step(1'b0, 32'h0, 1'b0);
        chk("fill_occ", 32'(occupancy), 32'(DEPTH));
        chk("fill_en",  32'(imem_en),   32'h0);

        // One pop leaves three entries; the following cycle reissues a request
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd3);

        // Redirect flush to 0x100
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("flush_vld",  32'(id_valid), 32'h0);
        chk("flush_addr", imem_addr,     32'h100);
        chk("flush_en",   32'(imem_en),  32'h1);
        step(1'b1, 32'h100, 1'b0);
        redirect_valid = 1'b0;
        #1;
        chk("flush_occ", 32'(occupancy), 32'h0);
        step(1'b0, 32'h0, 1'b1);
        id_ready = 1'b1;
        #1;
        chk("flush_first_vld", 32'(id_valid), 32'h1);
        chk("flush_first_pc",  id_pc,         32'h100);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Misaligned target
        step(1'b1, 32'h202, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects, both coinciding with id_ready=1
        step(1'b1, 32'h40, 1'b1);
        step(1'b1, 32'h80, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        id_ready = 1'b1;
        #1;
        chk("b2b_first_pc", id_pc, 32'h80);
        repeat (3) step(1'b0, 32'h0, 1'b1);

        // PC wrap across 2^32
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // Randomised traffic
        repeat (300) step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) != 0);

        // Async reset while half full with a request in flight
        step(1'b1, 32'h300, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("mid_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) step(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the single-register IF stage of the RV32I pipeline with a decoupled prefetch queue. It issues one sequential request per cycle to the synchronous IMEM port. Each returned instruction is buffered together with its PC in a DEPTH-entry FIFO. The buffer is presented to ID through a valid/ready handshake, so decode stalls no longer have to replay the fetch address. A redirect from EX (taken branch or jump) flushes the queue and any in-flight response in one cycle, then resumes fetch at the new target with no extra bubble.

## Interface
- XLEN, 32, PC/address width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  EX requests PC change this cycle
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored (treated as 0)
- imem_en  out  1  IMEM read request this cycle
- imem_addr  out  XLEN  IMEM byte address, word aligned
- imem_rdata  in  32  IMEM read data, valid the cycle after imem_en
- id_valid  out  1  head entry is presented to ID
- id_ready  in  1  ID accepts head entry
- id_instr  out  32  head instruction; 32'h00000013 (NOP) when id_valid=0
- id_pc  out  XLEN  PC of head instruction; 0 when id_valid=0
- occupancy  out  $clog2(DEPTH+1)  entries currently stored

## Operation
- **State:**
  - fetch_pc: next sequential address.
  - inflight flag and inflight_pc: one outstanding request.
  - FIFO of {instr, pc}, with rd_ptr/wr_ptr wrapping mod DEPTH and a count register.
- **Issue rule:**
  - When there is no redirect, issue if count + inflight < DEPTH.
  - On issue: imem_en=1, imem_addr=fetch_pc, fetch_pc <= fetch_pc+4 (wraps mod 2^XLEN), inflight <= 1, inflight_pc <= fetch_pc.
  - When no issue: imem_en=0, and imem_addr holds fetch_pc.
  - The credit check ignores a same-cycle pop, so it is conservative and overflow is impossible.
- **Response:**
  - If inflight=1 and there is no redirect, push {imem_rdata, inflight_pc} at wr_ptr.
  - The inflight flag clears unless a new request issues in the same cycle.
- **Pop:** when id_valid && id_ready, advance rd_ptr.
- **Count:**
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: a pushed entry is visible starting the following cycle.
- **Redirect (highest priority):**
  - The redirect_valid cycle:
    - flushes the FIFO: count, rd_ptr and wr_ptr go to 0;
    - discards the in-flight response arriving this cycle;
    - forces id_valid=0, so no pop occurs.
  - The same cycle also issues imem_addr={redirect_pc[XLEN-1:2],2'b00} with imem_en=1.
  - Resulting state: fetch_pc <= aligned redirect_pc+4, inflight <= 1.
  - Back-to-back redirects: each one supersedes the previous one.
- **Output:** id_valid = (count≠0) && !redirect_valid. id_instr and id_pc come from the head entry, or the NOP/0 pair when id_valid=0.

## Timing
- **Reset (async):**
  - fetch_pc=RESET_PC, count=0, pointers=0, inflight=0.
  - Outputs: imem_en=0, imem_addr=RESET_PC, id_valid=0, id_instr=NOP, id_pc=0, occupancy=0.
  - The first request (addr RESET_PC) issues in the first cycle after rst_n deasserts.
- **Latency:**
  - Request in cycle T, data on imem_rdata in T+1, written at the T+1 edge, id_valid in T+2.
  - Redirect in cycle T likewise gives id_valid in T+2 with id_pc equal to the aligned redirect_pc.
- **Throughput:** one instruction per cycle sustained when id_ready=1 continuously.
- **Full queue:**
  - With id_ready=0, the queue fills to DEPTH and imem_en drops to 0.
  - After the first pop, imem_en reasserts in the next cycle. The credit check ignores the pop cycle itself, so there is one bubble.
- **Reset asserted mid-operation:** state is cleared immediately. The pending IMEM response is never captured because inflight=0.

## Test plan
- **Reset and stream:** release reset with id_ready=1 and IMEM holding word i at address 4i. Required response:
  - imem_addr sequence 0,4,8,…;
  - id_valid first high in cycle 2, with id_pc=0 and id_instr equal to mem[0];
  - one instruction per cycle thereafter.
- **Backpressure fill:** hold id_ready=0. Required response:
  - occupancy reaches DEPTH (4), then imem_en=0 and occupancy holds at 4;
  - after id_ready=1, entries PCs 0,4,8,12 are delivered in order with no loss or duplicate.
- **Redirect flush:** queue holds 3 entries, then pulse redirect_valid with redirect_pc=0x100. Required response:
  - in the same cycle: id_valid=0, imem_addr=0x100, imem_en=1;
  - the next cycle: occupancy=0, and the discarded in-flight word is never presented;
  - two cycles later: id_pc=0x100, then 0x104.
- **Redirect corner cases:**
  - redirect_pc=0x202 → fetch at 0x200.
  - Redirect on two consecutive cycles (0x40 then 0x80) → first delivered id_pc=0x80.
  - Redirect coinciding with id_ready=1 → no pop counted.
- **PC wrap:** redirect_pc=0xFFFFFFFC with XLEN=32 → delivered id_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- **Async reset mid-stream:** assert rst_n low while the queue is half full with a request in flight. Required response:
  - outputs go to their reset values immediately;
  - after release, fetch restarts at RESET_PC with no stale entries.
